// File: rtl/window_gen_3x3_pkg.sv
// Shared constants for the 3x3 window generator and the window filters.
// Default frame geometry, pixel width and counter sizing.
package window_gen_3x3_pkg;

  localparam int DATA_W_DEF     = 8;
  localparam int IMG_WIDTH_DEF  = 512;
  localparam int IMG_HEIGHT_DEF = 512;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int COL_W_DEF = cnt_w(IMG_WIDTH_DEF);
  localparam int ROW_W_DEF = cnt_w(IMG_HEIGHT_DEF);

endpackage

// File: rtl/window_gen_3x3_if.sv
// Pixel-in / window-out handshake bundle.
// master = window generator, slave = source and filter side.
interface window_gen_3x3_if #(
  parameter int DATA_W = window_gen_3x3_pkg::DATA_W_DEF
);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_pixel;
  logic              in_sof;

  logic              out_valid;
  logic              out_ready;
  logic              out_last;
  logic [DATA_W-1:0] win1, win2, win3;
  logic [DATA_W-1:0] win4, win5, win6;
  logic [DATA_W-1:0] win7, win8, win9;

  modport master (
    input  in_valid, in_pixel, in_sof,
    input  out_ready,
    output in_ready,
    output out_valid, out_last,
    output win1, win2, win3,
    output win4, win5, win6,
    output win7, win8, win9
  );

  modport slave (
    output in_valid, in_pixel, in_sof,
    output out_ready,
    input  in_ready,
    input  out_valid, out_last,
    input  win1, win2, win3,
    input  win4, win5, win6,
    input  win7, win8, win9
  );

endinterface

// File: rtl/window_gen_3x3_line_buffer_rw.sv
// Single-port line RAM: combinational read of the addressed word,
// write of the same word at the clock edge (read-before-write).
module line_buffer_rw
  import window_gen_3x3_pkg::*;
#(
  parameter int DEPTH = IMG_WIDTH_DEF,
  parameter int WIDTH = 2 * DATA_W_DEF,
  localparam int AW   = cnt_w(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/window_gen_3x3.sv
// Streaming 3x3 window generator: two line buffers plus three
// column shift registers, one registered window per handshake.
module window_gen_3x3
  import window_gen_3x3_pkg::*;
#(
  parameter int IMG_WIDTH  = IMG_WIDTH_DEF,
  parameter int IMG_HEIGHT = IMG_HEIGHT_DEF,
  parameter int DATA_W     = DATA_W_DEF
) (
  input logic               clk,
  input logic               rst,
  window_gen_3x3_if.master  bus
);

  localparam int COL_W = cnt_w(IMG_WIDTH);
  localparam int ROW_W = cnt_w(IMG_HEIGHT);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

  logic [COL_W-1:0] col_q, col_d, cur_col;
  logic [ROW_W-1:0] row_q, row_d, cur_row;

  logic [DATA_W-1:0] top_q [3];
  logic [DATA_W-1:0] top_d [3];
  logic [DATA_W-1:0] mid_q [3];
  logic [DATA_W-1:0] mid_d [3];
  logic [DATA_W-1:0] bot_q [3];
  logic [DATA_W-1:0] bot_d [3];
  logic [DATA_W-1:0] win_q [9];
  logic [DATA_W-1:0] win_d [9];

  logic out_valid_q, out_valid_d;
  logic out_last_q, out_last_d;

  logic in_ready, accept, win_hit, frame_end;
  logic [DATA_W-1:0]   lb0_rd, lb1_rd;
  logic [2*DATA_W-1:0] lb_rd;

  assign in_ready  = !out_valid_q || bus.out_ready;
  assign accept    = bus.in_valid && in_ready;
  // sof pins the accepted pixel to (0,0) regardless of counters
  assign cur_col   = bus.in_sof ? '0 : col_q;
  assign cur_row   = bus.in_sof ? '0 : row_q;
  assign win_hit   = (cur_row >= ROW_W'(2)) && (cur_col >= COL_W'(2));
  assign frame_end = (cur_row == ROW_LAST) && (cur_col == COL_LAST);

  // Both line rows share one RAM word: {row r-2, row r-1}
  line_buffer_rw #(
    .DEPTH (IMG_WIDTH),
    .WIDTH (2 * DATA_W)
  ) u_lb (
    .clk   (clk),
    .we    (accept),
    .addr  (cur_col),
    .wdata ({lb0_rd, bus.in_pixel}),
    .rdata (lb_rd)
  );

  assign {lb1_rd, lb0_rd} = lb_rd;

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (accept) begin
      if (cur_col == COL_LAST) begin
        col_d = '0;
        row_d = (cur_row == ROW_LAST) ? '0 : cur_row + ROW_W'(1);
      end else begin
        col_d = cur_col + COL_W'(1);
        row_d = cur_row;
      end
    end
  end

  always_comb begin
    top_d = top_q;
    mid_d = mid_q;
    bot_d = bot_q;
    if (accept) begin
      top_d = '{top_q[1], top_q[2], lb1_rd};
      mid_d = '{mid_q[1], mid_q[2], lb0_rd};
      bot_d = '{bot_q[1], bot_q[2], bus.in_pixel};
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    win_d       = win_q;
    if (in_ready) begin
      out_valid_d = accept && win_hit;
      out_last_d  = accept && frame_end;
      win_d = '{top_d[0], top_d[1], top_d[2],
                mid_d[0], mid_d[1], mid_d[2],
                bot_d[0], bot_d[1], bot_d[2]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q       <= '0;
      row_q       <= '0;
      top_q       <= '{default: '0};
      mid_q       <= '{default: '0};
      bot_q       <= '{default: '0};
      win_q       <= '{default: '0};
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      top_q       <= top_d;
      mid_q       <= mid_d;
      bot_q       <= bot_d;
      win_q       <= win_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.win1 = win_q[0];
  assign bus.win2 = win_q[1];
  assign bus.win3 = win_q[2];
  assign bus.win4 = win_q[3];
  assign bus.win5 = win_q[4];
  assign bus.win6 = win_q[5];
  assign bus.win7 = win_q[6];
  assign bus.win8 = win_q[7];
  assign bus.win9 = win_q[8];

endmodule
